peak_dpu_lsu: RTL and testbench
===============================

# peak_dpu_lsu

Load/store execution unit that consumes the decoded load/store operation (3-bit `ls_op`, base register, immediate, store data, destination register) and performs the matching access on the single-port data-memory bus. It computes the effective address, checks alignment, drives byte enables and store-data lanes, waits for the memory handshake, then returns a sign- or zero-extended load result to register writeback. It sits in the DPU execute stage, downstream of the load/store decoder, and allows one outstanding access.

## Interface
- No parameters; data/address width fixed at 32.
- `clk` in 1 — sole clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `ls_vld` in 1 — decoded load/store valid.
- `ls_rdy` out 1 — unit can accept an op.
- `ls_op` in 3 — LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
- `ls_base` in 32 — rs1 value.
- `ls_imm` in 32 — sign-extended offset.
- `ls_wdata` in 32 — rs2 value (stores).
- `ls_rd` in 5 — load destination register.
- `ls_flush` in 1 — pipeline flush; kill the in-flight op.
- `mem_req` out 1 — bus request.
- `mem_we` out 1 — 1 = write.
- `mem_addr` out 32 — word-aligned address (bits [1:0] = 0).
- `mem_be` out 4 — byte enables.
- `mem_wdata` out 32 — lane-steered store data.
- `mem_gnt` in 1 — request accepted this cycle.
- `mem_rvld` in 1 — read data valid.
- `mem_rdata` in 32 — read data.
- `wb_vld` out 1 — load result valid (one-cycle pulse).
- `wb_rd` out 5 — writeback register.
- `wb_data` out 32 — extended load result.
- `exc_vld` out 1 — misaligned-access pulse.
- `exc_store` out 1 — 1 = store misaligned, 0 = load.
- `exc_addr` out 32 — faulting byte address.

## Operation
- EA = `ls_base + ls_imm`, mod 2^32, wrap-around ignored. Computed and registered at accept.
- Misaligned: halfword ops with EA[0]=1; word ops with EA[1:0]≠0. Byte ops never fault.
- Byte enables: byte = `4'b0001<<EA[1:0]`; half = `4'b0011<<EA[1:0]`; word = `4'b1111`.
- Store data is replicated across lanes: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- Load extraction: select the byte or half at EA[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- FSM states:
  - IDLE: `ls_rdy`=1. On `ls_vld`, capture the op. Misaligned goes to EXC; otherwise go to REQ.
  - REQ: `mem_req`=1 with address, control and data held stable. On `mem_gnt`, a store goes to IDLE and a load goes to RSP. If `ls_flush` is set and `mem_gnt` is not, go to IDLE and do not request.
  - RSP: wait for `mem_rvld`. Go to IDLE and pulse `wb_vld` next cycle unless the op is killed.
  - EXC: pulse `exc_vld`/`exc_store`/`exc_addr` for one cycle, then go to IDLE. No bus activity.
- `ls_flush` in RSP marks the op killed. The unit still waits for `mem_rvld` to drain the bus, and suppresses `wb_vld`.
- `ls_flush` in IDLE blocks acceptance that cycle.
- `ls_flush` in the same cycle as `mem_gnt`: the access is committed. A store completes; a load's writeback is suppressed.
- `wb_vld` is suppressed when `wb_rd` = 0.
- `mem_rvld` outside RSP is ignored.

## Timing
- Reset values: state IDLE, `ls_rdy`=1, every other output 0.
- Accept in cycle 0 → `mem_req` in cycle 1 (registered).
- Load, zero-wait memory: `mem_gnt` in cycle 1, `mem_rvld` in cycle 2, `wb_vld` in cycle 3. Minimum load latency is 3 cycles from accept.
- Store, `mem_gnt` in cycle 1: IDLE in cycle 2, so next accept in cycle 2. Store throughput is one per 2 cycles.
- Misaligned op: `exc_vld` in cycle 1, `ls_rdy` in cycle 2.
- `mem_req` stays high until `mem_gnt`; no combinational path from `mem_gnt` to `mem_req`.
- All outputs are registered, except `ls_rdy`, which is decoded from state only.
- Reset mid-operation returns the unit to IDLE next cycle and drops `mem_req`. A subsequent stray `mem_rvld` is ignored.

## Structure
- Shared package `peak_dpu_pkg`:
  - LS op localparams LB..SW (shared with the decoder).
  - FSM state encoding IDLE/REQ/RSP/EXC (2 bits).
- Sub-module `peak_dpu_lsu_align`: purely combinational. It generates `be`/lane-steered wdata from (op, EA[1:0], wdata) and load extraction/extension from (op, EA[1:0], rdata). The top level holds the FSM and registers.

## Test plan
- LW, base 0x1000, imm 0x8, `mem_gnt` immediate, rdata 0xDEADBEEF, rd 5 → `mem_addr` 0x1008, `mem_be` 0xF; `wb_vld` in cycle 3 with `wb_rd` 5 and `wb_data` 0xDEADBEEF.
- LB and LBU at EA 0x1003, rdata 0x80xxxxxx → LB gives `wb_data` 0xFFFFFF80; LBU gives 0x00000080.
- SH, EA 0x2002, wdata 0x1234ABCD, `mem_gnt` delayed 3 cycles → `mem_addr` 0x2000, `mem_be` 0xC, `mem_wdata` 0xABCDABCD, all held stable 4 cycles; no `wb_vld`.
- LW at EA 0x3001 → `exc_vld` pulse with `exc_store` 0 and `exc_addr` 0x3001; `mem_req` never asserted.
- Load with `ls_flush` asserted in RSP, `mem_rvld` 2 cycles later → no `wb_vld`, and `ls_rdy` returns afterwards.
- `rst` asserted during REQ → `mem_req` 0 next cycle; a later `mem_rvld` pulse produces no `wb_vld`.

Source files
------------

// File: rtl/peak_dpu_pkg.sv
// peak_dpu_pkg: shared load/store op codes, LSU state encoding and op-size helpers.
//    Op codes are shared with the load/store decoder.
package peak_dpu_pkg;
   localparam logic [2:0] LS_LB  = 3'd0;
   localparam logic [2:0] LS_LH  = 3'd1;
   localparam logic [2:0] LS_LW  = 3'd2;
   localparam logic [2:0] LS_LBU = 3'd3;
   localparam logic [2:0] LS_LHU = 3'd4;
   localparam logic [2:0] LS_SB  = 3'd5;
   localparam logic [2:0] LS_SH  = 3'd6;
   localparam logic [2:0] LS_SW  = 3'd7;
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP, ST_EXC} state_t;
   // access size code: 0 = byte, 1 = half, 2 = word
   function automatic logic [1:0] ls_size(input logic [2:0] op);
      return (op == LS_LB || op == LS_LBU || op == LS_SB) ? 2'd0 :
             (op == LS_LH || op == LS_LHU || op == LS_SH) ? 2'd1 : 2'd2;
   endfunction
   function automatic logic ls_is_store(input logic [2:0] op);
      return op >= LS_SB;
   endfunction
   function automatic logic ls_misaligned(input logic [2:0] op, input logic [1:0] ofs);
      return (ls_size(op) == 2'd1) ? ofs[0] : (ls_size(op) == 2'd2) ? |ofs : 1'b0;
   endfunction
endpackage

// File: rtl/peak_dpu_lsu_align.sv
// peak_dpu_lsu_align: combinational byte-lane steering for stores and extraction/extension for loads.
//    op         in  3  : load/store op code
//    ofs        in  2  : byte offset within word (EA[1:0])
//    wdata      in  32 : store data from register file
//    rdata      in  32 : raw word from memory
//    be         out 4  : byte enables
//    wdata_lane out 32 : store data replicated across lanes
//    rdata_ext  out 32 : extracted, sign/zero-extended load result
module peak_dpu_lsu_align
   import peak_dpu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  ofs,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);
   logic [1:0]  sz;
   logic [31:0] rsh;
   always_comb begin
      sz         = ls_size(op);
      rsh        = rdata >> {ofs, 3'b000};
      be         = (sz == 2'd0) ? 4'b0001 << ofs : (sz == 2'd1) ? 4'b0011 << ofs : 4'b1111;
      wdata_lane = (sz == 2'd0) ? {4{wdata[7:0]}} : (sz == 2'd1) ? {2{wdata[15:0]}} : wdata;
      rdata_ext  = (op == LS_LB)  ? {{24{rsh[7]}}, rsh[7:0]}   :
                   (op == LS_LBU) ? {24'd0, rsh[7:0]}           :
                   (op == LS_LH)  ? {{16{rsh[15]}}, rsh[15:0]} :
                   (op == LS_LHU) ? {16'd0, rsh[15:0]}          : rdata;
   end
endmodule

// File: rtl/peak_dpu_lsu.sv
// peak_dpu_lsu: load/store execution unit driving a single-port data-memory bus, one access outstanding.
//    clk, rst                           : clock, synchronous active-high reset
//    ls_vld/ls_rdy/ls_op/ls_base/ls_imm : decoded op handshake and operands
//    ls_wdata/ls_rd/ls_flush            : store data, load destination, pipeline flush
//    mem_req/we/addr/be/wdata           : registered bus request
//    mem_gnt/rvld/rdata                 : bus grant and read response
//    wb_vld/wb_rd/wb_data               : load writeback pulse
//    exc_vld/exc_store/exc_addr         : misaligned-access pulse
module peak_dpu_lsu
   import peak_dpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ls_vld,
   output logic        ls_rdy,
   input  logic [2:0]  ls_op,
   input  logic [31:0] ls_base,
   input  logic [31:0] ls_imm,
   input  logic [31:0] ls_wdata,
   input  logic [4:0]  ls_rd,
   input  logic        ls_flush,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvld,
   input  logic [31:0] mem_rdata,
   output logic        wb_vld,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        exc_vld,
   output logic        exc_store,
   output logic [31:0] exc_addr
);
   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d, al_op;
   logic [1:0]  ofs_q, ofs_d, al_ofs;
   logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
   logic        killed_q, killed_d;
   logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d, al_be;
   logic        wb_vld_q, wb_vld_d, exc_vld_q, exc_vld_d, exc_store_q, exc_store_d;
   logic [31:0] wb_data_q, wb_data_d, exc_addr_q, exc_addr_d;
   logic [31:0] ea, al_wdata, al_rdata;
   // one aligner serves both directions: live op in IDLE for steering, captured op in RSP for extraction
   assign ea     = ls_base + ls_imm;
   assign al_op  = (state_q == ST_IDLE) ? ls_op : op_q;
   assign al_ofs = (state_q == ST_IDLE) ? ea[1:0] : ofs_q;
   peak_dpu_lsu_align u_align (
      .op         (al_op),
      .ofs        (al_ofs),
      .wdata      (ls_wdata),
      .rdata      (mem_rdata),
      .be         (al_be),
      .wdata_lane (al_wdata),
      .rdata_ext  (al_rdata)
   );
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      ofs_d       = ofs_q;
      rd_d        = rd_q;
      killed_d    = killed_q;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_be_d    = '0;
      mem_wdata_d = '0;
      wb_vld_d    = 1'b0;
      wb_rd_d     = '0;
      wb_data_d   = '0;
      exc_vld_d   = 1'b0;
      exc_store_d = 1'b0;
      exc_addr_d  = '0;
      case (state_q)
         ST_IDLE: if (ls_vld && !ls_flush) begin
            op_d     = ls_op;
            ofs_d    = ea[1:0];
            rd_d     = ls_rd;
            killed_d = 1'b0;
            if (ls_misaligned(ls_op, ea[1:0])) begin
               state_d     = ST_EXC;
               exc_vld_d   = 1'b1;
               exc_store_d = ls_is_store(ls_op);
               exc_addr_d  = ea;
            end else begin
               state_d     = ST_REQ;
               mem_req_d   = 1'b1;
               mem_we_d    = ls_is_store(ls_op);
               mem_addr_d  = {ea[31:2], 2'b00};
               mem_be_d    = al_be;
               mem_wdata_d = al_wdata;
            end
         end
         ST_REQ: begin
            // a grant commits the access even if a flush arrives in the same cycle
            if (mem_gnt) begin
               state_d  = ls_is_store(op_q) ? ST_IDLE : ST_RSP;
               killed_d = ls_flush;
            end else if (ls_flush) begin
               state_d = ST_IDLE;
            end else begin
               mem_req_d   = 1'b1;
               mem_we_d    = mem_we_q;
               mem_addr_d  = mem_addr_q;
               mem_be_d    = mem_be_q;
               mem_wdata_d = mem_wdata_q;
            end
         end
         ST_RSP: begin
            killed_d = killed_q | ls_flush;
            if (mem_rvld) begin
               state_d   = ST_IDLE;
               wb_vld_d  = !(killed_q || ls_flush) && (rd_q != 5'd0);
               wb_rd_d   = rd_q;
               wb_data_d = al_rdata;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         ofs_q       <= '0;
         rd_q        <= '0;
         killed_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         wb_vld_q    <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         exc_vld_q   <= 1'b0;
         exc_store_q <= 1'b0;
         exc_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         ofs_q       <= ofs_d;
         rd_q        <= rd_d;
         killed_q    <= killed_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         wb_vld_q    <= wb_vld_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         exc_vld_q   <= exc_vld_d;
         exc_store_q <= exc_store_d;
         exc_addr_q  <= exc_addr_d;
      end
   end
   assign ls_rdy    = (state_q == ST_IDLE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_vld    = wb_vld_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign exc_vld   = exc_vld_q;
   assign exc_store = exc_store_q;
   assign exc_addr  = exc_addr_q;
endmodule

// File: tb/tb_peak_dpu_lsu.sv
// tb_peak_dpu_lsu: directed and randomized load/store sequences checked against an arithmetic reference model.
module tb_peak_dpu_lsu;
   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;
   logic        clk = 1'b0, rst = 1'b1;
   logic        ls_vld = 1'b0, ls_flush = 1'b0, mem_gnt = 1'b0, mem_rvld = 1'b0;
   logic [2:0]  ls_op = '0;
   logic [31:0] ls_base = '0, ls_imm = '0, ls_wdata = '0, mem_rdata = '0;
   logic [4:0]  ls_rd = '0;
   logic        ls_rdy, mem_req, mem_we, wb_vld, exc_vld, exc_store;
   logic [31:0] mem_addr, mem_wdata, wb_data, exc_addr;
   logic [3:0]  mem_be;
   logic [4:0]  wb_rd;
   int          n_assert = 0, n_fail = 0;
   always #5 clk = ~clk;
   peak_dpu_lsu dut (
      .clk(clk), .rst(rst), .ls_vld(ls_vld), .ls_rdy(ls_rdy), .ls_op(ls_op), .ls_base(ls_base),
      .ls_imm(ls_imm), .ls_wdata(ls_wdata), .ls_rd(ls_rd), .ls_flush(ls_flush), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvld(mem_rvld), .mem_rdata(mem_rdata), .wb_vld(wb_vld), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc_vld(exc_vld), .exc_store(exc_store), .exc_addr(exc_addr)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic int nbytes(input logic [2:0] op);
      if (op == LB || op == LBU || op == SB) return 1;
      if (op == LH || op == LHU || op == SH) return 2;
      return 4;
   endfunction
   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] ea, input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * (ea % 4));
      if (op == LB || op == LBU) begin
         v = v % 256;
         if (op == LB && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (op == LH || op == LHU) begin
         v = v % 65536;
         if (op == LH && v >= 32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction
   function automatic logic [31:0] ref_lanes(input logic [2:0] op, input logic [31:0] wd);
      if (nbytes(op) == 1) return (wd % 256) * 32'h0101_0101;
      if (nbytes(op) == 2) return (wd % 65536) * 32'h0001_0001;
      return wd;
   endfunction
   // fm: 0 = no flush, 1 = flush in first RSP cycle, 2 = flush together with grant
   task automatic do_op(input logic [2:0] op, input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int gd, input int rdl, input int fm);
      logic [31:0] ea;
      logic [3:0]  be;
      logic        st, mis, exp_wb;
      ea     = base + imm;
      st     = op >= SB;
      mis    = (ea % nbytes(op)) != 0;
      be     = 4'((32'd1 << nbytes(op)) - 1) << (ea % 4);
      exp_wb = (rd != 0) && (fm == 0);
      @(negedge clk);
      chk("rdy_before_accept", ls_rdy, 1);
      ls_vld = 1'b1; ls_op = op; ls_base = base; ls_imm = imm; ls_wdata = wd; ls_rd = rd;
      @(negedge clk);
      ls_vld = 1'b0;
      if (mis) begin
         chk("exc_vld", exc_vld, 1);
         chk("exc_store", exc_store, st);
         chk("exc_addr", exc_addr, ea);
         chk("exc_no_req", mem_req, 0);
         chk("exc_rdy_low", ls_rdy, 0);
         @(negedge clk);
         chk("exc_pulse_end", exc_vld, 0);
         chk("exc_rdy_back", ls_rdy, 1);
         chk("exc_no_req2", mem_req, 0);
         return;
      end
      for (int k = 0; k <= gd; k++) begin
         chk("req", mem_req, 1);
         chk("addr", mem_addr, ea & 32'hFFFF_FFFC);
         chk("be", mem_be, be);
         chk("we", mem_we, st);
         if (st) chk("wdata", mem_wdata, ref_lanes(op, wd));
         if (k == gd) begin
            mem_gnt = 1'b1;
            if (fm == 2) ls_flush = 1'b1;
         end
         @(negedge clk);
         mem_gnt = 1'b0; ls_flush = 1'b0;
      end
      chk("req_drop", mem_req, 0);
      if (st) begin
         chk("st_rdy", ls_rdy, 1);
         chk("st_no_wb", wb_vld, 0);
         return;
      end
      chk("rsp_rdy_low", ls_rdy, 0);
      for (int k = 0; k <= rdl; k++) begin
         if (k == 0 && fm == 1) ls_flush = 1'b1;
         if (k == rdl) begin
            mem_rvld = 1'b1; mem_rdata = rdata;
         end
         @(negedge clk);
         ls_flush = 1'b0; mem_rvld = 1'b0;
         if (k < rdl) chk("wb_wait", wb_vld, 0);
      end
      chk("wb_vld", wb_vld, exp_wb);
      if (exp_wb) begin
         chk("wb_rd", wb_rd, rd);
         chk("wb_data", wb_data, ref_load(op, ea, rdata));
      end
      chk("ld_rdy", ls_rdy, 1);
      @(negedge clk);
      chk("wb_pulse_end", wb_vld, 0);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_rdy", ls_rdy, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_wb", wb_vld, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_exc", exc_vld, 0);
      chk("rst_exc_addr", exc_addr, 0);
      do_op(LW, 32'h1000, 32'h8, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
      do_op(LB, 32'h1000, 32'h3, 32'h0, 5'd7, 32'h8012_3456, 0, 0, 0);
      do_op(LBU, 32'h1000, 32'h3, 32'h0, 5'd7, 32'h8012_3456, 0, 0, 0);
      do_op(SH, 32'h2000, 32'h2, 32'h1234_ABCD, 5'd0, 32'h0, 3, 0, 0);
      do_op(LW, 32'h3000, 32'h1, 32'h0, 5'd3, 32'h0, 0, 0, 0);
      do_op(SW, 32'h3000, 32'h2, 32'h0, 5'd3, 32'h0, 0, 0, 0);
      do_op(LW, 32'h4000, 32'h0, 32'h0, 5'd9, 32'h1111_2222, 0, 2, 1);
      do_op(LH, 32'h4000, 32'h2, 32'h0, 5'd9, 32'h8001_0000, 1, 1, 2);
      do_op(SB, 32'h5000, 32'h1, 32'hA5, 5'd0, 32'h0, 0, 0, 2);
      do_op(LHU, 32'h5000, 32'h2, 32'h0, 5'd0, 32'hF00D_0000, 0, 0, 0);
      do_op(LH, 32'h6000, 32'h2, 32'h0, 5'd4, 32'hF00D_0000, 0, 0, 0);
      // flush in IDLE blocks acceptance
      @(negedge clk);
      ls_vld = 1'b1; ls_flush = 1'b1; ls_op = LW; ls_base = 32'h7000; ls_imm = 32'h0;
      @(negedge clk);
      ls_vld = 1'b0; ls_flush = 1'b0;
      chk("idle_flush_no_req", mem_req, 0);
      chk("idle_flush_rdy", ls_rdy, 1);
      // flush in REQ without grant abandons the request
      ls_vld = 1'b1;
      @(negedge clk);
      ls_vld = 1'b0;
      chk("req_flush_req", mem_req, 1);
      ls_flush = 1'b1;
      @(negedge clk);
      ls_flush = 1'b0;
      chk("req_flush_drop", mem_req, 0);
      chk("req_flush_rdy", ls_rdy, 1);
      // reset during REQ, then a stray response
      ls_vld = 1'b1; ls_rd = 5'd6;
      @(negedge clk);
      ls_vld = 1'b0;
      chk("rst_mid_req", mem_req, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_drop", mem_req, 0);
      chk("rst_mid_rdy", ls_rdy, 1);
      mem_rvld = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_rvld = 1'b0;
      chk("stray_rvld_wb", wb_vld, 0);
      @(negedge clk);
      chk("stray_rvld_wb2", wb_vld, 0);
      for (int i = 0; i < 60; i++) begin
         do_op(3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 15)) - 32'd8, $urandom,
               5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
               ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
